// File: rtl/averager_pkg.sv
// Shared types and helpers for the trigger-synchronous averager.
// Holds the state encoding, the fixed ADC lane width and sign extension.
package averager_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        ACQ,
        DRAIN,
        DONE
    } state_t;

    localparam int LANE_W = 16;
    localparam int SEXT_W = 64;

    // Bit offset of channel c inside the packed ADC input bus.
    function automatic int lane_lo(input int c);
        return c * LANE_W;
    endfunction

    // Sign-extend the low adc_w bits of a lane; callers truncate to their accumulator width.
    function automatic logic [SEXT_W-1:0] sext(input logic [LANE_W-1:0] raw, input int adc_w);
        logic signed [SEXT_W-1:0] t;
        t = $signed(SEXT_W'(raw) << (SEXT_W - adc_w));
        return t >>> (SEXT_W - adc_w);
    endfunction

endpackage

// File: rtl/avg_lane.sv
// One channel: delays the ADC sample to meet BRAM read data, then adds (or overwrites on pass 0).
// Result registered one cycle after read data arrives; no backpressure.
module avg_lane
    import averager_pkg::*;
#(
    parameter int ADC_W  = 14,
    parameter int ACC_W  = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic [LANE_W-1:0] sample,
    input  logic              wr_stage,
    input  logic              first,
    input  logic [ACC_W-1:0]  rd_lane,
    output logic [ACC_W-1:0]  wr_lane
);

    logic [RD_LAT*LANE_W-1:0] smp_d;
    logic [ACC_W-1:0]         sext_smp;
    logic [ACC_W-1:0]         addend;

    assign sext_smp = ACC_W'(sext(smp_d[RD_LAT*LANE_W-1 -: LANE_W], ADC_W));
    assign addend   = first ? '0 : rd_lane;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            smp_d   <= '0;
            wr_lane <= '0;
        end else begin
            smp_d <= (RD_LAT*LANE_W)'({smp_d, sample});
            // Wraps modulo 2**ACC_W by design.
            if (wr_stage) wr_lane <= sext_smp + addend;
        end
    end

endmodule

// File: rtl/averager_multi.sv
// Trigger-synchronous multi-channel averager accumulating NSAMPLES-long records into BRAM.
// Write for read k lands RD_LAT+1 cycles later; no backpressure, one sample/cycle/channel.
module averager_multi
    import averager_pkg::*;
#(
    parameter int NCH    = 2,
    parameter int ADC_W  = 14,
    parameter int ACC_W  = 32,
    parameter int ADDR_W = 14,
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  trig,
    input  logic [NCH*LANE_W-1:0] data_in,
    input  logic [ADDR_W:0]       nsamples,
    input  logic [31:0]           naverages,
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic [NCH*ACC_W-1:0]  rd_data,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [NCH*ACC_W-1:0]  wr_data,
    output logic                  wr_en,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           avg_count
);

    state_t                   state, state_n;
    logic                     trig_q, trig_rise;
    logic [ADDR_W:0]          cfg_nsamples;
    logic [31:0]              cfg_naverages;
    logic [1:0]               drain_cnt;
    logic                     acq, last_rd, drain_end, flush, wr_stage, first;
    logic [RD_LAT-1:0]        vld_d;
    logic [RD_LAT*ADDR_W-1:0] addr_d;

    assign trig_rise = trig & ~trig_q;
    assign flush     = start | abort;
    assign last_rd   = ({1'b0, rd_addr} == cfg_nsamples - (ADDR_W+1)'(1));
    assign wr_stage  = vld_d[RD_LAT-1] & ~flush;
    assign first     = (avg_count == '0);
    assign busy      = (state == ARMED) || (state == ACQ) || (state == DRAIN);
    assign done      = (state == DONE);

    always_comb begin
        state_n   = state;
        acq       = 1'b0;
        drain_end = 1'b0;
        if (abort) begin
            state_n = IDLE;
        end else if (start) begin
            state_n = (nsamples == '0 || naverages == '0) ? DONE : ARMED;
        end else begin
            case (state)
                ARMED: begin
                    // The edge cycle itself is read/sample index 0.
                    if (trig_rise) begin
                        acq     = 1'b1;
                        state_n = last_rd ? DRAIN : ACQ;
                    end
                end
                ACQ: begin
                    acq = 1'b1;
                    if (last_rd) state_n = DRAIN;
                end
                DRAIN: begin
                    if (drain_cnt == 2'(RD_LAT)) begin
                        drain_end = 1'b1;
                        state_n   = (avg_count + 32'd1 < cfg_naverages) ? ARMED : DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= IDLE;
            trig_q        <= 1'b0;
            rd_addr       <= '0;
            avg_count     <= '0;
            drain_cnt     <= '0;
            cfg_nsamples  <= '0;
            cfg_naverages <= '0;
            vld_d         <= '0;
            addr_d        <= '0;
            wr_en         <= 1'b0;
            wr_addr       <= '0;
        end else begin
            state  <= state_n;
            trig_q <= trig;
            if (flush) begin
                // Dropping the valid pipe suppresses writes still in flight.
                rd_addr   <= '0;
                avg_count <= '0;
                drain_cnt <= '0;
                vld_d     <= '0;
                if (!abort) begin
                    cfg_nsamples  <= nsamples;
                    cfg_naverages <= naverages;
                end
            end else begin
                vld_d <= RD_LAT'({vld_d, acq});
                if (acq) rd_addr <= last_rd ? '0 : rd_addr + ADDR_W'(1);
                if (state == DRAIN) drain_cnt <= drain_end ? 2'd0 : drain_cnt + 2'd1;
                if (drain_end) avg_count <= avg_count + 32'd1;
            end
            addr_d <= (RD_LAT*ADDR_W)'({addr_d, rd_addr});
            wr_en  <= wr_stage;
            if (wr_stage) wr_addr <= addr_d[RD_LAT*ADDR_W-1 -: ADDR_W];
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_lane
        avg_lane #(
            .ADC_W  (ADC_W),
            .ACC_W  (ACC_W),
            .RD_LAT (RD_LAT)
        ) u_lane (
            .clk      (clk),
            .aresetn  (aresetn),
            .sample   (data_in[lane_lo(c) +: LANE_W]),
            .wr_stage (wr_stage),
            .first    (first),
            .rd_lane  (rd_data[c*ACC_W +: ACC_W]),
            .wr_lane  (wr_data[c*ACC_W +: ACC_W])
        );
    end

endmodule
